// File: rtl/closest_hit_scheduler.sv
// closest_hit_scheduler: walks every sphere through the distance calculator for one ray
// and returns the closest intersection as a single hit record.
module closest_hit_scheduler #(
    parameter int NUM_SPHERES = 8,
    parameter int IDX_W = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1,
    parameter int DIST_W = 16,
    parameter logic [DIST_W-1:0] MAX_DIST = {DIST_W{1'b1}},
    parameter int RAY_ID_W = 8
) (
    input  logic                CLK,
    input  logic                areset,
    input  logic                ray_valid,
    output logic                ray_ready,
    input  logic [RAY_ID_W-1:0] ray_id,
    output logic                calc_in_valid,
    input  logic                calc_in_ready,
    output logic [IDX_W-1:0]    calc_sphere_idx,
    output logic [DIST_W-1:0]   calc_old_dist,
    input  logic                calc_out_valid,
    input  logic                calc_intersects,
    input  logic [DIST_W-1:0]   calc_distance,
    output logic                hit_valid,
    input  logic                hit_ready,
    output logic                hit,
    output logic [DIST_W-1:0]   hit_distance,
    output logic [IDX_W-1:0]    hit_sphere,
    output logic [RAY_ID_W-1:0] hit_ray_id,
    output logic                busy,
    output logic                err_unexpected
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SPHERES - 1);

    state_t state, next;
    logic [IDX_W-1:0] idx;
    logic [DIST_W-1:0] best;

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            idx <= '0;
            best <= MAX_DIST;
            hit_sphere <= '0;
            hit <= 1'b0;
            hit_ray_id <= '0;
            err_unexpected <= 1'b0;
        end else begin
            state <= next;
            if (calc_out_valid && state != WAIT)
                err_unexpected <= 1'b1;
            if (state == IDLE && ray_valid) begin
                hit_ray_id <= ray_id;
                best <= MAX_DIST;
                hit_sphere <= '0;
                hit <= 1'b0;
                idx <= '0;
            end
            if (state == WAIT && calc_out_valid) begin
                // strict compare keeps the lower index on ties and rejects MAX_DIST
                if (calc_intersects && calc_distance < best) begin
                    best <= calc_distance;
                    hit_sphere <= idx;
                    hit <= 1'b1;
                end
                if (idx != LAST)
                    idx <= idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:  next = ray_valid ? ISSUE : IDLE;
            ISSUE: next = calc_in_ready ? WAIT : ISSUE;
            WAIT:  next = !calc_out_valid ? WAIT : (idx == LAST) ? DONE : ISSUE;
            DONE:  next = hit_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    assign ray_ready = state == IDLE;
    assign calc_in_valid = state == ISSUE;
    assign calc_sphere_idx = idx;
    assign calc_old_dist = (state == ISSUE) ? best : '0;
    assign hit_valid = state == DONE;
    assign hit_distance = best;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_closest_hit_scheduler.sv
// tb_closest_hit_scheduler: randomized and directed rays against a min-distance reference model.
module tb_closest_hit_scheduler;
    localparam int N = 4;
    localparam logic [15:0] MAXD = 16'hFFFF;

    logic CLK = 1'b0;
    logic areset, ray_valid, ray_ready, calc_in_valid, calc_in_ready, calc_out_valid;
    logic calc_intersects, hit_valid, hit_ready, hit, busy, err_unexpected;
    logic [7:0] ray_id, hit_ray_id;
    logic [1:0] calc_sphere_idx, hit_sphere;
    logic [15:0] calc_old_dist, calc_distance, hit_distance;

    closest_hit_scheduler #(.NUM_SPHERES(N), .IDX_W(2), .DIST_W(16), .MAX_DIST(MAXD), .RAY_ID_W(8)) dut (
        .CLK(CLK), .areset(areset), .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_id(ray_id),
        .calc_in_valid(calc_in_valid), .calc_in_ready(calc_in_ready), .calc_sphere_idx(calc_sphere_idx),
        .calc_old_dist(calc_old_dist), .calc_out_valid(calc_out_valid), .calc_intersects(calc_intersects),
        .calc_distance(calc_distance), .hit_valid(hit_valid), .hit_ready(hit_ready), .hit(hit),
        .hit_distance(hit_distance), .hit_sphere(hit_sphere), .hit_ray_id(hit_ray_id), .busy(busy),
        .err_unexpected(err_unexpected)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [15:0] dist_t[N];
    logic int_t[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // closest hitting sphere among the first n results, lowest index winning ties
    task automatic model(input int n, output logic h, output logic [15:0] d, output int s);
        h = 1'b0;
        d = MAXD;
        s = 0;
        for (int j = 0; j < n; j++)
            if (int_t[j] && dist_t[j] != MAXD && (!h || dist_t[j] < d)) begin
                h = 1'b1;
                d = dist_t[j];
                s = j;
            end
    endtask

    task automatic run_ray(input logic [7:0] id, input int lat, input int in_stall,
                           input int hit_stall, input int abort_at);
        logic h;
        logic [15:0] d;
        int s, t, c0;
        t = 0;
        while (!ray_ready && t < 100) begin step; t++; end
        chk("ray_ready_wait", ray_ready, 1);
        ray_valid = 1'b1;
        ray_id = id;
        c0 = cyc;
        step;
        ray_valid = 1'b0;
        ray_id = 8'($urandom);
        for (int i = 0; i < N; i++) begin
            t = 0;
            while (!calc_in_valid && t < 100) begin step; t++; end
            chk("issue_wait", calc_in_valid, 1);
            model(i, h, d, s);
            chk("issue_idx", calc_sphere_idx, i);
            chk("old_dist", calc_old_dist, d);
            for (int k = 0; k < in_stall && i == 1; k++) begin
                step;
                chk("hold_valid", calc_in_valid, 1);
                chk("hold_idx", calc_sphere_idx, i);
                chk("hold_old_dist", calc_old_dist, d);
            end
            calc_in_ready = 1'b1;
            step;
            calc_in_ready = 1'b0;
            chk("wait_no_valid", calc_in_valid, 0);
            if (i == abort_at) begin
                #2 areset = 1'b1;
                #1;
                chk("abort_ray_ready", ray_ready, 1);
                chk("abort_busy", busy, 0);
                chk("abort_in_valid", calc_in_valid, 0);
                chk("abort_hit_valid", hit_valid, 0);
                chk("abort_hit", hit, 0);
                chk("abort_hit_dist", hit_distance, MAXD);
                chk("abort_old_dist", calc_old_dist, 0);
                step;
                areset = 1'b0;
                return;
            end
            repeat (lat - 1) step;
            calc_out_valid = 1'b1;
            calc_intersects = int_t[i];
            calc_distance = dist_t[i];
            step;
            calc_out_valid = 1'b0;
            calc_intersects = 1'($urandom);
            calc_distance = 16'($urandom);
        end
        t = 0;
        while (!hit_valid && t < 100) begin step; t++; end
        chk("hit_wait", hit_valid, 1);
        if (in_stall == 0)
            chk("latency", cyc - c0, 1 + N * (1 + lat));
        model(N, h, d, s);
        for (int k = 0; k <= hit_stall; k++) begin
            chk("rec_valid", hit_valid, 1);
            chk("rec_hit", hit, h);
            chk("rec_dist", hit_distance, d);
            chk("rec_sphere", hit_sphere, s);
            chk("rec_id", hit_ray_id, id);
            chk("rec_no_ray_ready", ray_ready, 0);
            if (k < hit_stall) step;
        end
        hit_ready = 1'b1;
        step;
        hit_ready = 1'b0;
        chk("after_ray_ready", ray_ready, 1);
        chk("after_busy", busy, 0);
        chk("after_hit_valid", hit_valid, 0);
    endtask

    initial begin
        areset = 1'b1;
        ray_valid = 1'b0;
        ray_id = '0;
        calc_in_ready = 1'b0;
        calc_out_valid = 1'b0;
        calc_intersects = 1'b0;
        calc_distance = '0;
        hit_ready = 1'b0;
        repeat (3) step;
        chk("rst_ray_ready", ray_ready, 1);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_in_valid", calc_in_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_unexpected, 0);
        chk("rst_hit_dist", hit_distance, MAXD);
        areset = 1'b0;
        step;

        dist_t = '{16'd8, 16'd0, 16'd5, 16'd9};
        int_t = '{1'b1, 1'b0, 1'b1, 1'b1};
        run_ray(8'hA5, 1, 0, 0, -1);

        for (int j = 0; j < N; j++) begin
            dist_t[j] = 16'($urandom);
            int_t[j] = 1'b0;
        end
        run_ray(8'h3C, 2, 0, 0, -1);

        dist_t = '{16'd7, 16'd0, 16'd7, 16'd7};
        int_t = '{1'b1, 1'b0, 1'b1, 1'b1};
        run_ray(8'h11, 1, 0, 0, -1);

        dist_t = '{MAXD, 16'd3, 16'd4, 16'd5};
        int_t = '{1'b1, 1'b0, 1'b0, 1'b0};
        run_ray(8'h22, 3, 0, 0, -1);

        dist_t = '{16'd9, 16'd2, 16'd6, 16'd2};
        int_t = '{1'b1, 1'b1, 1'b0, 1'b1};
        run_ray(8'h33, 1, 3, 5, -1);

        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < N; j++) begin
                dist_t[j] = ($urandom_range(0, 7) == 0) ? MAXD : 16'($urandom_range(0, 12));
                int_t[j] = 1'($urandom);
            end
            run_ray(8'($urandom), $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        chk("err_clean", err_unexpected, 0);

        run_ray(8'h44, 1, 0, 0, 2);
        chk("post_abort_err", err_unexpected, 0);
        calc_out_valid = 1'b1;
        step;
        calc_out_valid = 1'b0;
        chk("idle_result_err", err_unexpected, 1);
        chk("idle_result_ray_ready", ray_ready, 1);

        dist_t = '{16'd4, 16'd3, 16'd2, 16'd1};
        int_t = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_ray(8'h55, 2, 0, 1, -1);
        chk("err_sticky", err_unexpected, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
